// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect flush and HALT stop; FETCH_PERF_CNT_EN enables the fetch counter
module fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic [INSTR_W-1:0] r_out_instr;
  logic [INSTR_W-1:0] w_out_instr_nxt;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [ADDR_W-1:0]  w_out_pc_nxt;
  logic               w_fetch_en;
  logic               w_is_halt;

  // A word is consumed only when running, not being redirected, and the output slot is free or draining
  assign w_fetch_en = (r_state == S_RUN) && !redirect_valid && (!r_out_valid || out_ready);
  assign w_is_halt  = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = (r_state == S_HALT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next pc and next output slot; redirect outranks fetch and drain
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    if (redirect_valid) begin
      w_state_nxt     = S_RUN;
      w_pc_nxt        = redirect_pc;
      w_out_valid_nxt = 1'b0;
    end else if (w_fetch_en) begin
      w_out_valid_nxt = 1'b1;
      w_out_instr_nxt = imem_instr;
      w_out_pc_nxt    = r_pc;
      if (w_is_halt) begin
        w_state_nxt = S_HALT;
      end else begin
        w_pc_nxt = r_pc + ADDR_W'(1);
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // Program counter and output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;

  // Saturating count of consumed memory words, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_fetch_en && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random and directed stimulus
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [256];

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_pc;
  logic        m_halt;
  logic [15:0] m_cnt;
  bit          chk;
  int          total;
  int          bad;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the architectural sequence of words decode should see
  initial begin
    chk = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_pc   = 8'h00;
        m_halt = 1'b0;
        m_cnt  = 16'h0;
        chk    = 1;
      end else if (redirect_valid) begin
        q.delete();
        m_pc   = redirect_pc;
        m_halt = 1'b0;
      end else if (chk && !m_halt && q.size() == 0) begin
        exp_t e;
        e.pc    = m_pc;
        e.instr = mem[m_pc];
        q.push_back(e);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (e.instr[15:12] == 4'hF) m_halt = 1'b1;
        else m_pc = m_pc + 8'd1;
      end
    end
  end

  // Monitor: compare the presented word and pop it when decode takes it
  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        check("valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
        if (q.size() != 0) begin
          check("out_pc", {24'b0, out_pc}, {24'b0, q[0].pc});
          check("out_instr", {16'b0, out_instr}, {16'b0, q[0].instr});
        end
        check("imem_addr", {24'b0, imem_addr}, {24'b0, m_pc});
        check("halted", {31'b0, halted}, {31'b0, m_halt});
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", {16'b0, fetch_count}, {16'b0, m_cnt});
`else
        check("fetch_count", {16'b0, fetch_count}, 32'h0);
`endif
        if (q.size() != 0 && out_ready && !redirect_valid && !rst) void'(q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [7:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] prog [6];
    total = 0;
    bad   = 0;
    prog[0] = 16'h4205; prog[1] = 16'h440A; prog[2] = 16'h0650;
    prog[3] = 16'h1E88; prog[4] = 16'h560A; prog[5] = 16'hF000;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
    step(2);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_addr", {24'b0, imem_addr}, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // straight-line program into HALT
    step(1);
    check("first_pc", {24'b0, out_pc}, 32'h0);
    step(9);
    check("halt_addr", {24'b0, imem_addr}, 32'h5);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_drained", {31'b0, out_valid}, 32'h0);

    // backpressure after the first fetch
    redirect(8'h00);
    step(1);
    out_ready = 1'b0;
    step(3);
    check("stall_pc", {24'b0, out_pc}, 32'h0);
    check("stall_instr", {16'b0, out_instr}, 32'h4205);
    check("stall_addr", {24'b0, imem_addr}, 32'h1);
    out_ready = 1'b1;
    step(1);
    check("release_pc", {24'b0, out_pc}, 32'h1);
    check("release_instr", {16'b0, out_instr}, 32'h440A);
    step(6);

    // redirect with flush while a word is held
    redirect(8'h00);
    step(2);
    redirect(8'h20);
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    check("flush_addr", {24'b0, imem_addr}, 32'h20);
    step(1);
    check("target_pc", {24'b0, out_pc}, 32'h20);

    // resume from HALT
    redirect(8'h00);
    step(10);
    redirect(8'h00);
    check("resume_halted", {31'b0, halted}, 32'h0);
    step(1);
    check("resume_pc", {24'b0, out_pc}, 32'h0);

    // pc wrap
    mem[255] = 16'h1234;
    redirect(8'hFF);
    step(1);
    check("wrap_ff", {24'b0, out_pc}, 32'hFF);
    step(1);
    check("wrap_00", {24'b0, out_pc}, 32'h0);

    // reset mid-stream
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_instr", {16'b0, out_instr}, 32'h0);
    check("mid_rst_pc", {24'b0, out_pc}, 32'h0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_addr", {24'b0, imem_addr}, 32'h0);

    // random traffic
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      rst            = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
